cell_share_arbiter: RTL and testbench
=====================================

Name: cell_share_arbiter

Overview:
Round-robin scheduler that time-shares one gate-level evaluation cell among N_REQ requesters. The cell is a mux of BUF/NOT/NAND/NOR instances with propagation delay. Each accepted request drives the cell inputs, waits SETTLE clock cycles for the output to settle, samples cell_y and returns the result to the originating requester. It sits between requester FSMs and the shared cell wrapper in the gate-level test harness.

Parameters:
N_REQ, 4, number of requesters (2..8)
SETTLE, 2, cycles between driving cell inputs and sampling cell_y (>=1)
CNT_W, 16, width of completed-operation counter

Ports:
C  input  1  clock, all state updates on rising edge
R  input  1  reset, synchronous, active-high
req_valid  input  N_REQ  per-requester request valid
req_op  input  2*N_REQ  per-requester opcode, slice i = [2i+1:2i]; 00 BUF, 01 NOT, 10 NAND, 11 NOR
req_a  input  N_REQ  per-requester operand A
req_b  input  N_REQ  per-requester operand B (ignored for BUF/NOT)
req_ready  output  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
cell_op  output  2  registered opcode to shared cell
cell_a  output  1  registered operand A to shared cell
cell_b  output  1  registered operand B; forced 0 for BUF/NOT
cell_y  input  1  shared cell output
rsp_valid  output  N_REQ  one-hot, one-cycle result strobe to the owning requester
rsp_y  output  1  sampled result, held until next response
busy  output  1  high in WAIT
op_count  output  CNT_W  completed operations, wraps modulo 2^CNT_W

Behaviour:
- Clock C, reset R: synchronous, active-high. R sampled high at a rising edge of C clears all state. R has priority over every other event.
- Reset values: state=IDLE, rr_ptr=0, cell_op=0, cell_a=0, cell_b=0, rsp_valid=0, rsp_y=0, busy=0, op_count=0, settle counter=0.
- States:
  - IDLE -> WAIT on a grant.
  - WAIT -> IDLE when the counter expires.
- IDLE, grant rule:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready is combinational: one-hot winner while in IDLE, all-zero in WAIT or when no valid.
  - At the grant edge: latch winner index; cell_op/a/b <= request fields (cell_b<=0 if op[1]=0); counter<=SETTLE-1; rr_ptr<=(winner+1) mod N_REQ; state<=WAIT.
  - No valid in IDLE: rr_ptr unchanged.
- WAIT:
  - busy=1; counter decrements each edge.
  - At the edge where the counter is 0: rsp_y<=cell_y; rsp_valid<=onehot(winner); op_count<=op_count+1; state<=IDLE.
- Timing:
  - Grant at edge E0 -> cell_y sampled at edge E0+SETTLE -> rsp_valid high during the cycle after E0+SETTLE.
  - Request-to-response latency = SETTLE+1 cycles.
  - rsp_valid is cleared at the next edge.
- Back-to-back: IDLE in the rsp_valid cycle may grant immediately. Max throughput = 1 op per SETTLE+1 cycles.
- Responses have no backpressure. Requesters must capture rsp_y during their rsp_valid cycle.
- Requests are not dropped: a requester holding valid is guaranteed a grant within N_REQ grants (starvation-free).
- cell_* outputs hold their last values in IDLE (no glitch to 0 between ops).
- Reset mid-WAIT: operation discarded, no rsp_valid; op_count returns to 0.
- op_count wraps from 2^CNT_W-1 to 0 without flag.
- req_valid deasserted while not granted: legal, no effect.
- req fields changing during WAIT: no effect on the in-flight operation.

Test Plan:
- Reset: hold R=1 for 2 cycles with all req_valid=1 -> req_ready=0000, rsp_valid=0000, cell_op/a/b=0, op_count=0.
- Single NAND: SETTLE=2, req 2 valid op=10 a=1 b=1, bench cell model delay <2 cycles:
  - req_ready=0100 in cycle 0
  - cell_a=cell_b=1 after grant edge
  - rsp_valid=0100 with rsp_y=0 exactly 3 cycles after grant
  - op_count=1
- Round robin: all 4 requesters valid continuously with NOR a=0 b=0 -> grant order 0,1,2,3,0, each response rsp_y=1, one grant every 3 cycles.
- BUF/NOT operand handling: req 1 NOT a=0 b=1 -> cell_b=0, rsp_y=1; req 3 BUF a=1 -> rsp_y=1.
- Reset mid-op: assert R at the edge after grant -> no rsp_valid ever asserted for that op; next grant goes to the lowest valid index (rr_ptr=0).
- Counter wrap: CNT_W=4, 17 ops -> op_count reads 15 then 0 then 1.

Source files
------------

// File: rtl/cell_share_arbiter.sv
// Round-robin time-sharing of one gate-level evaluation cell.
// Grants a requester, holds the cell inputs SETTLE cycles, returns cell_y.
module cell_share_arbiter #(
  parameter int N_REQ  = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic               C,
  input  logic               R,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [2*N_REQ-1:0] req_op,
  input  logic [N_REQ-1:0]   req_a,
  input  logic [N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [1:0]         cell_op,
  output logic               cell_a,
  output logic               cell_b,
  input  logic               cell_y,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic               rsp_y,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [1:0]         cell_op_q, cell_op_d;
  logic               cell_a_q, cell_a_d;
  logic               cell_b_q, cell_b_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               rsp_y_q, rsp_y_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      sel;
  logic [IW:0]        sum;
  logic [N_REQ-1:0]   win_oh;
  logic [N_REQ-1:0]   own_oh;

  // Rotating search starting at rr_ptr; sum is wide enough for 2*N_REQ-2.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    sel       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) begin
        sum = sum - (IW+1)'(N_REQ);
      end
      sel = sum[IW-1:0];
      if (!win_found && req_valid[sel]) begin
        win_found = 1'b1;
        win_idx   = sel;
      end
    end
  end

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
    own_oh          = '0;
    own_oh[win_q]   = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    cell_op_d   = cell_op_q;
    cell_a_d    = cell_a_q;
    cell_b_d    = cell_b_q;
    rsp_valid_d = '0;
    rsp_y_d     = rsp_y_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = WAIT;
          win_d     = win_idx;
          cell_op_d = req_op[{win_idx, 1'b0} +: 2];
          cell_a_d  = req_a[win_idx];
          cell_b_d  = req_op[{win_idx, 1'b1}] & req_b[win_idx];
          cnt_d     = SW'(SETTLE - 1);
          rr_ptr_d  = (win_idx == IW'(N_REQ - 1)) ? '0
                    : win_idx + IW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          rsp_y_d     = cell_y;
          rsp_valid_d = own_oh;
          op_count_d  = op_count_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      cell_op_q   <= '0;
      cell_a_q    <= 1'b0;
      cell_b_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_y_q     <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      cell_op_q   <= cell_op_d;
      cell_a_q    <= cell_a_d;
      cell_b_q    <= cell_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      op_count_q  <= op_count_d;
    end
  end

  assign req_ready = (state_q == IDLE && win_found && !R) ? win_oh : '0;
  assign cell_op   = cell_op_q;
  assign cell_a    = cell_a_q;
  assign cell_b    = cell_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = (state_q == WAIT);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_cell_share_arbiter.sv
// Bench for cell_share_arbiter: delayed gate cell model,
// per-cycle reference model and response scoreboard.
module tb_cell_share_arbiter;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int CW = 4;

  logic           C = 1'b0;
  logic           R = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [2*N-1:0] req_op = '0;
  logic [N-1:0]   req_a = '0;
  logic [N-1:0]   req_b = '0;
  logic [N-1:0]   req_ready;
  logic [1:0]     cell_op;
  logic           cell_a;
  logic           cell_b;
  logic           cell_y = 1'b0;
  logic [N-1:0]   rsp_valid;
  logic           rsp_y;
  logic           busy;
  logic [CW-1:0]  op_count;

  cell_share_arbiter #(.N_REQ(N), .SETTLE(S), .CNT_W(CW)) dut (
    .C(C), .R(R),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .cell_op(cell_op), .cell_a(cell_a), .cell_b(cell_b),
    .cell_y(cell_y),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y),
    .busy(busy), .op_count(op_count)
  );

  always #5 C = ~C;

  function automatic logic gate(input logic [1:0] op,
                                input logic a, input logic b);
    case (op)
      2'b00:   return a;
      2'b01:   return ~a;
      2'b10:   return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  // Shared cell with 3 ns propagation delay.
  always @(cell_op or cell_a or cell_b) begin
    #3;
    cell_y = gate(cell_op, cell_a, cell_b);
  end

  typedef struct {
    int         due;
    logic [N-1:0] oh;
    logic       y;
  } rsp_t;

  rsp_t          sbq[$];
  int            gidx[$];
  int            gcyc[$];
  int            ocs[$];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            m_ptr, m_wait, exp_w;
  logic [CW-1:0] m_cnt;
  logic [1:0]    m_op;
  logic          m_a, m_b, m_rsp_y;
  logic [N-1:0]  exp_ready, exp_rv;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_wait  = 0;
    m_cnt   = '0;
    m_op    = '0;
    m_a     = 1'b0;
    m_b     = 1'b0;
    m_rsp_y = 1'b0;
    sbq.delete();
  endtask

  task automatic tick();
    @(negedge C);
    exp_ready = '0;
    exp_w     = -1;
    if (!R && m_wait == 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (exp_w < 0 && req_valid[j]) exp_w = j;
      end
    end
    if (exp_w >= 0) exp_ready[exp_w] = 1'b1;
    exp_rv = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_rv  = sbq[0].oh;
      m_rsp_y = sbq[0].y;
      void'(sbq.pop_front());
      ocs.push_back(int'(op_count));
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_wait > 0));
    chk("cell_op", 32'(cell_op), 32'(m_op));
    chk("cell_a", 32'(cell_a), 32'(m_a));
    chk("cell_b", 32'(cell_b), 32'(m_b));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_y", 32'(rsp_y), 32'(m_rsp_y));
    for (int k = 0; k < N; k++) begin
      if (req_ready[k]) begin
        gidx.push_back(k);
        gcyc.push_back(cyc);
      end
    end
    @(posedge C);
    if (R) begin
      model_reset();
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_cnt = m_cnt + 1'b1;
    end else if (exp_w >= 0) begin
      rsp_t e;
      m_op  = req_op[2*exp_w +: 2];
      m_a   = req_a[exp_w];
      m_b   = m_op[1] ? req_b[exp_w] : 1'b0;
      e.due = cyc + S + 1;
      e.oh  = exp_ready;
      e.y   = gate(m_op, req_a[exp_w], req_b[exp_w]);
      sbq.push_back(e);
      m_ptr  = (exp_w + 1) % N;
      m_wait = S;
    end
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    req_valid = '1;
    @(posedge C);
    #1;
    // Reset held with every requester asking.
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);

    // Single NAND on requester 2.
    R         = 1'b0;
    req_valid = 4'b0100;
    req_op    = 8'b00_10_00_00;
    req_a     = 4'b0100;
    req_b     = 4'b0100;
    tick();
    req_valid = '0;
    chk("nand_cell_a", 32'(cell_a), 32'h1);
    chk("nand_cell_b", 32'(cell_b), 32'h1);
    repeat (4) tick();
    chk("nand_count", 32'(op_count), 32'h1);

    // Round robin, all NOR 0/0.
    R = 1'b1;
    tick();
    R = 1'b0;
    gidx.delete();
    gcyc.delete();
    req_valid = '1;
    req_op    = 8'hFF;
    req_a     = '0;
    req_b     = '0;
    repeat (13) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("rr_ngrants", 32'(gidx.size()), 32'd5);
    if (gidx.size() == 5) begin
      chk("rr_g0", 32'(gidx[0]), 32'd0);
      chk("rr_g1", 32'(gidx[1]), 32'd1);
      chk("rr_g2", 32'(gidx[2]), 32'd2);
      chk("rr_g3", 32'(gidx[3]), 32'd3);
      chk("rr_g4", 32'(gidx[4]), 32'd0);
      for (int k = 1; k < 5; k++)
        chk("rr_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
    end

    // NOT on requester 1 (b ignored), BUF on requester 3.
    req_valid = 4'b1010;
    req_op    = 8'b00_00_01_00;
    req_a     = 4'b1000;
    req_b     = 4'b1010;
    tick();
    chk("not_cell_b", 32'(cell_b), 32'h0);
    repeat (5) tick();
    req_valid = '0;
    repeat (4) tick();

    // Reset the edge after a grant: the operation must vanish.
    req_valid = 4'b0100;
    req_op    = 8'b00_10_00_00;
    tick();
    R         = 1'b1;
    req_valid = 4'b1010;
    tick();
    R = 1'b0;
    tick();
    chk("post_rst_cnt", 32'(op_count), 32'h0);
    req_valid = '0;
    repeat (4) tick();

    // 17 BUF ops on a 4-bit counter.
    R = 1'b1;
    tick();
    R = 1'b0;
    ocs.delete();
    req_valid = 4'b0001;
    req_op    = 8'h00;
    req_a     = 4'b0001;
    repeat (49) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("wrap_nrsp", 32'(ocs.size()), 32'd17);
    if (ocs.size() == 17) begin
      chk("wrap_15", 32'(ocs[14]), 32'd15);
      chk("wrap_0", 32'(ocs[15]), 32'd0);
      chk("wrap_1", 32'(ocs[16]), 32'd1);
    end
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
